deskew_ctrl_rx: RTL and testbench

Receive-side deskew controller that sequences the per-lane deskew buffers. It waits for all lanes to reach block lock and alignment-marker lock, then measures inter-lane skew from the first alignment-marker (AM) arrival on each lane. It checks that deskewed AMs come out on every lane together, and raises `align_status_o`. On lock loss, excess skew or repeated misaligned AMs it flushes the deskew buffers and restarts.

---
 rtl/deskew_pkg.sv | 25 ++
 rtl/deskew_skew_meas_rx.sv | 78 +++++++
 rtl/deskew_ctrl_rx.sv | 144 ++++++++++++++
 tb/tb_deskew_ctrl_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deskew_pkg.sv
// Shared types and defaults for the receive-side lane deskew controller.
// Imported by the skew measurement unit and the controller top.
package deskew_pkg;

  typedef enum logic [2:0] {
    LOCK_WAIT,
    MEASURE,
    ALIGN_WAIT,
    ALIGNED,
    FLUSH
  } deskew_ctrl_state_e;

  // Whole blocks of skew that fit in a buffer of skew_bits after one block.
  function automatic int dsk_max_skew_blocks(
    input int skew_bits,
    input int blk_bits
  );
    return (skew_bits - blk_bits - 1) / blk_bits;
  endfunction

  localparam int DSK_MAX_SKEW_BLOCK_N = dsk_max_skew_blocks(1856, 66);
  localparam int DSK_AM_PERIOD        = 16384;
  localparam int DSK_MISMATCH_N       = 3;

endpackage

// File: rtl/deskew_skew_meas_rx.sv
// Inter-lane skew measurement from the first AM seen on each lane.
// Error is registered; done is combinational for the controller.
module deskew_skew_meas_rx
  import deskew_pkg::*;
#(
  parameter int LANE_N           = 4,
  parameter int MAX_SKEW_BLOCK_N = DSK_MAX_SKEW_BLOCK_N,
  parameter int SKEW_W           = $clog2(MAX_SKEW_BLOCK_N + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic [LANE_N-1:0] i_am_v,
  output logic              o_done,
  output logic              o_err,
  output logic [SKEW_W-1:0] o_skew
);

  localparam logic [SKEW_W-1:0] LIMIT = SKEW_W'(MAX_SKEW_BLOCK_N + 1);

  logic              r_started;
  logic              r_err;
  logic [SKEW_W-1:0] r_cnt;
  logic [SKEW_W-1:0] r_skew;
  logic [LANE_N-1:0] r_seen;

  logic              w_meas;
  logic              w_active;
  logic              w_all;
  logic              w_dup;
  logic              w_err;
  logic [SKEW_W-1:0] w_cnt;

  always_comb begin
    w_meas   = i_start & ~r_err;
    w_active = r_started | (|i_am_v);
    w_cnt    = '0;
    if (r_started) begin
      w_cnt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    end
    w_all  = &(r_seen | i_am_v);
    w_dup  = |(r_seen & i_am_v);
    o_done = w_meas & w_all;
    // completion in the limit cycle beats the limit
    w_err  = w_meas & w_active & ~w_all &
             (w_dup | (w_cnt >= LIMIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_started <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_seen    <= '0;
      r_skew    <= '0;
    end else if (i_clear) begin
      r_started <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_seen    <= '0;
    end else begin
      r_err <= w_err;
      if (w_meas) begin
        r_started <= w_active;
        r_cnt     <= w_cnt;
        r_seen    <= r_seen | i_am_v;
        if (o_done) begin
          r_skew <= w_cnt;
        end
      end
    end
  end

  assign o_err  = r_err;
  assign o_skew = r_skew;

endmodule

// File: rtl/deskew_ctrl_rx.sv
// Receive deskew controller: lock wait, skew measure, alignment watch.
// Flushes the deskew buffers on lock loss, excess skew or bad AMs.
module deskew_ctrl_rx
  import deskew_pkg::*;
#(
  parameter int LANE_N           = 4,
  parameter int MAX_SKEW_BLOCK_N = DSK_MAX_SKEW_BLOCK_N,
  parameter int AM_PERIOD        = DSK_AM_PERIOD,
  parameter int MISMATCH_N       = DSK_MISMATCH_N,
  parameter int SKEW_W           = $clog2(MAX_SKEW_BLOCK_N + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANE_N-1:0] valid_i,
  input  logic [LANE_N-1:0] am_lock_i,
  input  logic [LANE_N-1:0] am_v_i,
  input  logic [LANE_N-1:0] am_dsk_v_i,
  output logic              deskew_flush_o,
  output logic              align_status_o,
  output logic [SKEW_W-1:0] skew_o,
  output logic              skew_err_o
);

  localparam int TMR_W = $clog2(AM_PERIOD + MAX_SKEW_BLOCK_N + 1);
  localparam int MM_W  = $clog2(MISMATCH_N + 1);

  localparam logic [TMR_W-1:0] AW_LIMIT =
    TMR_W'(AM_PERIOD + MAX_SKEW_BLOCK_N);
  localparam logic [TMR_W-1:0] AL_LIMIT = TMR_W'(AM_PERIOD + 1);
  localparam logic [MM_W-1:0]  MM_LIMIT = MM_W'(MISMATCH_N);

  deskew_ctrl_state_e r_state;
  deskew_ctrl_state_e w_next;

  logic [TMR_W-1:0] r_tmr;
  logic [MM_W-1:0]  r_mm;
  logic [MM_W-1:0]  w_mm;
  logic             r_flush;
  logic             r_align;

  logic w_lock_ok;
  logic w_am_full;
  logic w_am_any;
  logic w_meas;
  logic w_done;
  logic w_err;
  logic w_tmr_rst;
  logic w_tmr_zero;

  assign w_lock_ok = &(valid_i & am_lock_i);
  assign w_am_full = &am_dsk_v_i;
  assign w_am_any  = |am_dsk_v_i;
  assign w_meas    = (r_state == MEASURE);

  deskew_skew_meas_rx #(
    .LANE_N           (LANE_N),
    .MAX_SKEW_BLOCK_N (MAX_SKEW_BLOCK_N),
    .SKEW_W           (SKEW_W)
  ) u_meas (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_meas),
    .i_clear (~w_meas),
    .i_am_v  (am_v_i),
    .o_done  (w_done),
    .o_err   (w_err),
    .o_skew  (skew_o)
  );

  always_comb begin
    w_next     = r_state;
    w_tmr_rst  = 1'b0;
    w_tmr_zero = 1'b0;
    w_mm       = r_mm;
    unique case (r_state)
      LOCK_WAIT: begin
        if (w_lock_ok && !(|am_v_i)) w_next = MEASURE;
      end
      MEASURE: begin
        if (!w_lock_ok || w_err) begin
          w_next = FLUSH;
        end else if (w_done) begin
          w_next     = ALIGN_WAIT;
          w_tmr_zero = 1'b1;
        end
      end
      ALIGN_WAIT: begin
        if (!w_lock_ok) begin
          w_next = FLUSH;
        end else if (w_am_full) begin
          w_next    = ALIGNED;
          w_tmr_rst = 1'b1;
          w_mm      = '0;
        end else if (w_am_any || r_tmr >= AW_LIMIT) begin
          w_next = FLUSH;
        end
      end
      ALIGNED: begin
        if (!w_lock_ok) begin
          w_next = FLUSH;
        end else if (w_am_full) begin
          w_tmr_rst = 1'b1;
          w_mm      = '0;
        end else if (w_am_any || r_tmr >= AL_LIMIT) begin
          w_tmr_rst = 1'b1;
          w_mm      = r_mm + 1'b1;
          if (w_mm >= MM_LIMIT) w_next = FLUSH;
        end
      end
      FLUSH:   w_next = LOCK_WAIT;
      default: w_next = LOCK_WAIT;
    endcase
  end

  // Timer reads 0 in the cycle of the restarting AM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOCK_WAIT;
      r_tmr   <= '0;
      r_mm    <= '0;
      r_flush <= 1'b0;
      r_align <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flush <= (w_next == FLUSH);
      r_align <= (w_next == ALIGNED);
      r_mm    <= (w_next == ALIGNED) ? w_mm : '0;
      if (w_next != ALIGN_WAIT && w_next != ALIGNED) begin
        r_tmr <= '0;
      end else if (w_tmr_zero) begin
        r_tmr <= '0;
      end else if (w_tmr_rst) begin
        r_tmr <= TMR_W'(1);
      end else if (!(&r_tmr)) begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign deskew_flush_o = r_flush;
  assign align_status_o = r_align;
  assign skew_err_o     = w_err;

endmodule

// File: tb/tb_deskew_ctrl_rx.sv
// Scoreboard bench for deskew_ctrl_rx: expected outputs are queued with
// each stimulus cycle and compared one time unit after the clock edge.
module tb_deskew_ctrl_rx;
  import deskew_pkg::*;

  localparam int LANE_N = 4;
  localparam int MAXS   = 27;
  localparam int AMP    = 512;
  localparam int MMN    = 3;
  localparam int SKEW_W = $clog2(MAXS + 2);

  logic              clk = 1'b0;
  logic              reset;
  logic [LANE_N-1:0] valid_i;
  logic [LANE_N-1:0] am_lock_i;
  logic [LANE_N-1:0] am_v_i;
  logic [LANE_N-1:0] am_dsk_v_i;
  logic              deskew_flush_o;
  logic              align_status_o;
  logic [SKEW_W-1:0] skew_o;
  logic              skew_err_o;

  always #5 clk = ~clk;

  deskew_ctrl_rx #(
    .LANE_N           (LANE_N),
    .MAX_SKEW_BLOCK_N (MAXS),
    .AM_PERIOD        (AMP),
    .MISMATCH_N       (MMN),
    .SKEW_W           (SKEW_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .am_lock_i      (am_lock_i),
    .am_v_i         (am_v_i),
    .am_dsk_v_i     (am_dsk_v_i),
    .deskew_flush_o (deskew_flush_o),
    .align_status_o (align_status_o),
    .skew_o         (skew_o),
    .skew_err_o     (skew_err_o)
  );

  typedef struct {
    string             tag;
    logic              al;
    logic              fl;
    logic              er;
    logic [SKEW_W-1:0] sk;
  } exp_t;

  exp_t              sb[$];
  int                n_chk = 0;
  int                n_err = 0;
  logic [SKEW_W-1:0] m_skew;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic expect_o(
    input string tag,
    input logic  al,
    input logic  fl,
    input logic  er
  );
    exp_t e;
    e.tag = tag;
    e.al  = al;
    e.fl  = fl;
    e.er  = er;
    e.sk  = m_skew;
    sb.push_back(e);
  endtask

  task automatic exp_idle(input string tag);
    expect_o(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".align"}, 32'(align_status_o), 32'(e.al));
      chk({e.tag, ".flush"}, 32'(deskew_flush_o), 32'(e.fl));
      chk({e.tag, ".err"},   32'(skew_err_o),     32'(e.er));
      chk({e.tag, ".skew"},  32'(skew_o),         32'(e.sk));
    end
  endtask

  // Drives AM offsets up to tend; the caller steps the final cycle.
  task automatic measure(input int off[4], input int tend);
    for (int t = 0; t <= tend; t++) begin
      for (int l = 0; l < LANE_N; l++) am_v_i[l] = (off[l] == t);
      if (t < tend) begin
        exp_idle("meas");
        step();
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    valid_i    = '0;
    am_lock_i  = '0;
    am_v_i     = '0;
    am_dsk_v_i = '0;
    m_skew     = '0;
    step();
    exp_idle("rst");
    step();
    reset = 1'b0;
    exp_idle("nolock");
    step();

    valid_i   = '1;
    am_lock_i = '1;
    exp_idle("lw");
    step();
    measure('{0, 5, 12, 20}, 20);
    m_skew = 20;
    exp_idle("skew20");
    step();
    am_v_i     = '0;
    am_dsk_v_i = '1;
    expect_o("align", 1'b1, 1'b0, 1'b0);
    step();
    am_dsk_v_i = '0;
    expect_o("hold", 1'b1, 1'b0, 1'b0);
    step();

    valid_i[2] = 1'b0;
    am_dsk_v_i = '1;
    expect_o("lloss", 1'b0, 1'b1, 1'b0);
    step();
    valid_i    = '1;
    am_dsk_v_i = '0;
    exp_idle("lloss_end");
    step();
    exp_idle("lw2");
    step();

    measure('{0, 28, -1, -1}, 28);
    expect_o("skerr", 1'b0, 1'b0, 1'b1);
    step();
    am_v_i = '0;
    expect_o("skflush", 1'b0, 1'b1, 1'b0);
    step();
    exp_idle("sk_end");
    step();
    exp_idle("lw3");
    step();

    measure('{0, 0, 0, 28}, 28);
    m_skew = 28;
    exp_idle("skew28");
    step();
    am_v_i     = '0;
    am_dsk_v_i = 4'b0011;
    expect_o("awpart", 1'b0, 1'b1, 1'b0);
    step();
    am_dsk_v_i = '0;
    exp_idle("awp_end");
    step();
    exp_idle("lw4");
    step();

    am_v_i = 4'b0001;
    exp_idle("pre_rst");
    step();
    am_v_i = '0;
    step();
    reset  = 1'b1;
    m_skew = '0;
    exp_idle("rst_mid");
    step();
    reset = 1'b0;
    exp_idle("rst_noflush");
    step();

    am_v_i = '1;
    exp_idle("zero_skew");
    step();
    am_v_i     = '0;
    am_dsk_v_i = '1;
    expect_o("zs_align", 1'b1, 1'b0, 1'b0);
    step();

    for (int k = 0; k < 2; k++) begin
      am_dsk_v_i = 4'b0111;
      expect_o("mm_part", 1'b1, 1'b0, 1'b0);
      step();
      expect_o("mm_part", 1'b1, 1'b0, 1'b0);
      step();
      if (k == 0) begin
        am_dsk_v_i = '1;
        expect_o("mm_full", 1'b1, 1'b0, 1'b0);
        step();
      end
    end
    expect_o("mm_third", 1'b0, 1'b1, 1'b0);
    step();
    am_dsk_v_i = '0;
    exp_idle("mm_end");
    step();

    exp_idle("lw5");
    step();
    am_v_i = '1;
    step();
    am_v_i     = '0;
    am_dsk_v_i = '1;
    expect_o("miss_align", 1'b1, 1'b0, 1'b0);
    step();
    am_dsk_v_i = '0;
    repeat (3 * (AMP + 1) - 2) step();
    expect_o("miss_pre", 1'b1, 1'b0, 1'b0);
    step();
    expect_o("miss_third", 1'b0, 1'b1, 1'b0);
    step();
    exp_idle("miss_end");
    step();
    exp_idle("lw6");
    step();

    am_v_i = 4'b0001;
    step();
    am_v_i = '0;
    step();
    step();
    am_v_i = 4'b0001;
    expect_o("dup", 1'b0, 1'b0, 1'b1);
    step();
    am_v_i = '0;
    expect_o("dup_flush", 1'b0, 1'b1, 1'b0);
    step();
    exp_idle("dup_end");
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
